// File: rtl/lector_teclado.sv
// 4x4 matrix-keypad scanner: rotates the active-low column drive, debounces press and release,
// and emits one push strobe with the key's hex code per physical key press.
module lector_teclado #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] entrada,
  output logic       push
);

  localparam int unsigned TickW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  CntDone  = CntW'(DEBOUNCE_TICKS);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e           state_q, state_d;
  logic [3:0]       filas_meta_q, filas_sync_q;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [3:0]       entrada_q, entrada_d;
  logic             push_q, push_d;

  logic       tick;
  logic       any_low;
  logic       row_held;
  logic [1:0] low_row;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // Rows are asynchronous to clk; every decision below uses filas_sync_q only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filas_meta_q <= 4'hF;
      filas_sync_q <= 4'hF;
    end else begin
      filas_meta_q <= filas;
      filas_sync_q <= filas_meta_q;
    end
  end

  assign tick       = (tick_cnt_q == TickLast);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  assign any_low    = ~&filas_sync_q;
  assign row_held   = ~filas_sync_q[row_q];

  // Lowest-index low row wins when several rows are low together.
  always_comb begin
    low_row = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!filas_sync_q[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    count_d   = count_q;
    entrada_d = entrada_q;
    push_d    = 1'b0;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (any_low) begin
            row_d   = low_row;
            count_d = CntOne;
            state_d = StDebounce;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        StDebounce: begin
          if (row_held) begin
            count_d = count_q + 1'b1;
            if (count_d == CntDone) begin
              entrada_d = key_code(row_q, col_q);
              push_d    = 1'b1;
              state_d   = StPressed;
            end
          end else begin
            state_d = StScan;
            col_d   = col_q + 2'd1;
          end
        end
        StPressed: begin
          if (!any_low) begin
            count_d = CntOne;
            state_d = StRelease;
          end
        end
        StRelease: begin
          if (!any_low) begin
            count_d = count_q + 1'b1;
            if (count_d == CntDone) begin
              state_d = StScan;
              col_d   = col_q + 2'd1;
            end
          end else begin
            state_d = StPressed;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StScan;
      tick_cnt_q <= '0;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      count_q    <= '0;
      entrada_q  <= 4'h0;
      push_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      count_q    <= count_d;
      entrada_q  <= entrada_d;
      push_q     <= push_d;
    end
  end

  assign columnas = ~(4'b0001 << col_q);
  assign entrada  = entrada_q;
  assign push     = push_q;

endmodule

// File: tb/tb_lector_teclado.sv
// Bench for lector_teclado: a keypad emulator closes the column/row loop, a behavioural
// model predicts columnas/entrada/push every cycle, plus directed literal checks.
module tb_lector_teclado;

  localparam int SD = 4;
  localparam int DT = 3;

  localparam int Hunting    = 0;
  localparam int Confirming = 1;
  localparam int Holding    = 2;
  localparam int Releasing  = 3;

  // Index r*4+c, keypad legend 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
  localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] entrada;
  logic       push;

  logic [15:0] keys_down = '0;
  logic        force_en  = 1'b1;
  logic [3:0]  force_val = 4'h0;
  logic [3:0]  emu_rows;

  int n_checks = 0;
  int n_pass   = 0;
  int pushes   = 0;

  lector_teclado #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .filas   (filas),
    .columnas(columnas),
    .entrada (entrada),
    .push    (push)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    emu_rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys_down[r*4+c] && !columnas[c]) emu_rows[r] = 1'b0;
      end
    end
  end
  assign filas = force_en ? force_val : emu_rows;

  // Behavioural model
  logic [3:0] m_s1, m_s2, m_code;
  logic       m_push;
  int         m_phase, m_col, m_mode, m_row, m_stable;

  function automatic int lowest_low(input logic [3:0] v);
    int low;
    low = 0;
    for (int r = 3; r >= 0; r--) if (!v[r]) low = r;
    return low;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_s1 <= 4'hF; m_s2 <= 4'hF; m_code <= 4'h0; m_push <= 1'b0;
      m_phase <= 0; m_col <= 0; m_mode <= Hunting; m_row <= 0; m_stable <= 0;
    end else begin
      m_s1    <= filas;
      m_s2    <= m_s1;
      m_push  <= 1'b0;
      m_phase <= (m_phase + 1) % SD;
      if (m_phase == SD - 1) begin
        case (m_mode)
          Hunting:
            if (m_s2 != 4'hF) begin
              m_row <= lowest_low(m_s2); m_stable <= 1; m_mode <= Confirming;
            end else m_col <= (m_col + 1) % 4;
          Confirming:
            if (!m_s2[m_row]) begin
              m_stable <= m_stable + 1;
              if (m_stable + 1 >= DT) begin
                m_code <= KEYMAP[m_row*4+m_col]; m_push <= 1'b1; m_mode <= Holding;
              end
            end else begin
              m_mode <= Hunting; m_col <= (m_col + 1) % 4;
            end
          Holding:
            if (m_s2 == 4'hF) begin
              m_stable <= 1; m_mode <= Releasing;
            end
          default:
            if (m_s2 == 4'hF) begin
              m_stable <= m_stable + 1;
              if (m_stable + 1 >= DT) begin
                m_mode <= Hunting; m_col <= (m_col + 1) % 4;
              end
            end else m_mode <= Holding;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [3:0] exp_col;
    exp_col = 4'hF ^ (4'b0001 << m_col);
    check("model_columnas", columnas, exp_col);
    check("model_entrada", entrada, m_code);
    check("model_push", {3'b0, push}, {3'b0, m_push});
    if (push === 1'b1) pushes++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_push(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (push === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_mode(input int mode, input int stable, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(negedge clk);
      if (m_mode == mode && (stable < 0 || m_stable == stable)) ok = 1'b1;
    end
  endtask

  int         rot_k   [5] = '{3, 4, 8, 12, 16};
  logic [3:0] rot_col [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int         sweep_idx [5] = '{12, 14, 13, 15, 3};
  logic [3:0] sweep_code[5] = '{4'hE, 4'hF, 4'h0, 4'hD, 4'hA};

  initial begin
    bit ok;
    int p0;
    rst = 1'b0;

    // Reset with all rows low.
    cycles(3);
    check("reset_columnas", columnas, 4'b1110);
    check("reset_entrada", entrada, 4'h0);
    check("reset_push", {3'b0, push}, 4'h0);

    // Release and observe free rotation.
    @(negedge clk);
    force_val = 4'hF;
    rst = 1'b1;
    for (int k = 1, j = 0; k <= 16; k++) begin
      @(negedge clk);
      if (j < 5 && k == rot_k[j]) begin
        check("rotation", columnas, rot_col[j]);
        j++;
      end
    end

    // Clean press of '5' (row 1, column 1).
    force_en = 1'b0;
    p0 = pushes;
    keys_down = 16'b1 << 5;
    cycles(40);
    keys_down = '0;
    cycles(30);
    check("press5_entrada", entrada, 4'h5);
    check("press5_pushes", 4'(pushes - p0), 4'd1);

    // Bounce: row low for exactly one sampling tick.
    p0 = pushes;
    force_en  = 1'b1;
    force_val = 4'b1011;
    cycles(SD);
    force_val = 4'hF;
    cycles(20);
    check("bounce_pushes", 4'(pushes - p0), 4'd0);
    check("bounce_entrada", entrada, 4'h5);
    force_en = 1'b0;

    // Mapping sweep: * # 0 D A.
    for (int s = 0; s < 5; s++) begin
      p0 = pushes;
      keys_down = 16'b1 << sweep_idx[s];
      wait_push(200, ok);
      check("sweep_push_seen", {3'b0, ok}, 4'd1);
      cycles(8);
      keys_down = '0;
      cycles(40);
      check("sweep_entrada", entrada, sweep_code[s]);
      check("sweep_pushes", 4'(pushes - p0), 4'd1);
    end

    // Two rows under column 2, then a re-press during the release window.
    p0 = pushes;
    keys_down = (16'b1 << 10) | (16'b1 << 14);
    wait_push(200, ok);
    check("two_rows_push_seen", {3'b0, ok}, 4'd1);
    check("two_rows_entrada", entrada, 4'h9);
    cycles(4);
    keys_down = '0;
    wait_mode(Releasing, -1, 50, ok);
    check("two_rows_releasing", {3'b0, ok}, 4'd1);
    keys_down = 16'b1 << 10;
    wait_mode(Holding, -1, 20, ok);
    check("two_rows_back_to_held", {3'b0, ok}, 4'd1);
    cycles(8);
    keys_down = '0;
    cycles(40);
    check("two_rows_pushes", 4'(pushes - p0), 4'd1);

    // Reset asserted after the second debounce tick of a '1' press.
    p0 = pushes;
    keys_down = 16'b1 << 0;
    wait_mode(Confirming, 2, 200, ok);
    check("mid_reset_reached", {3'b0, ok}, 4'd1);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_columnas", columnas, 4'b1110);
    check("mid_reset_entrada", entrada, 4'h0);
    check("mid_reset_push", {3'b0, push}, 4'h0);
    keys_down = '0;
    cycles(3);
    rst = 1'b1;
    cycles(40);
    check("mid_reset_pushes", 4'(pushes - p0), 4'd0);
    check("mid_reset_entrada_after", entrada, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
